// File: rtl/desplazador_dac_tx_if.sv
// Bus between the product-register reader and the serial DAC transmitter:
// start strobe and product in, saturated sample, serial pins and status out.
interface desplazador_dac_tx_if #(
    parameter int N     = 25,
    parameter int DAC_W = 12
);
    logic               bandera;
    logic [2*N-1:0]     fk_in;
    logic [DAC_W-1:0]   dato_sat;
    logic               sync_n;
    logic               sclk;
    logic               sdo;
    logic               busy;
    logic               done;
    logic               overrun;

    modport master (
        output bandera, fk_in,
        input  dato_sat, sync_n, sclk, sdo, busy, done, overrun
    );

    modport slave (
        input  bandera, fk_in,
        output dato_sat, sync_n, sclk, sdo, busy, done, overrun
    );
endinterface

// File: rtl/desplazador_dac_tx.sv
// Rescales and saturates the signed filter product, converts it to offset binary
// and shifts {CTRL, data} MSB-first onto a 3-wire DAC link.
module desplazador_dac_tx #(
    parameter int         N     = 25,
    parameter int         FRAC  = 12,
    parameter int         DAC_W = 12,
    parameter logic [3:0] CTRL  = 4'b0011,
    parameter int         DIV   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    desplazador_dac_tx_if.slave  bus
);
    localparam int FW = DAC_W + 4;
    localparam int W2 = 2 * N;
    localparam int PW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
    localparam int BW = $clog2(FW);

    localparam logic signed [W2-1:0] SAT_MAX = {{(W2-DAC_W+1){1'b0}}, {(DAC_W-1){1'b1}}};
    localparam logic signed [W2-1:0] SAT_MIN = {{(W2-DAC_W+1){1'b1}}, {(DAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Shift at full width, then clamp before dropping the upper bits.
    function automatic logic [DAC_W-1:0] sat_fn(input logic signed [W2-1:0] fk);
        logic signed [W2-1:0] s;
        s = fk >>> FRAC;
        if (s > SAT_MAX) begin
            return SAT_MAX[DAC_W-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[DAC_W-1:0];
        end else begin
            return s[DAC_W-1:0];
        end
    endfunction

    function automatic logic [FW-1:0] frame_fn(input logic [DAC_W-1:0] sat);
        return {CTRL, ~sat[DAC_W-1], sat[DAC_W-2:0]};
    endfunction

    state_t           state_r,   state_s;
    logic [PW-1:0]    phase_r,   phase_s;
    logic [BW-1:0]    bit_r,     bit_s;
    logic [FW-1:0]    shreg_r,   shreg_s;
    logic [DAC_W-1:0] dato_r,    dato_s;
    logic             sync_n_r,  sync_n_s;
    logic             sclk_r,    sclk_s;
    logic             sdo_r,     sdo_s;
    logic             busy_r,    busy_s;
    logic             done_r,    done_s;
    logic             overrun_r, overrun_s;
    logic [DAC_W-1:0] sat_s;
    logic [FW-1:0]    frame_s;

    assign sat_s   = sat_fn($signed(bus.fk_in));
    assign frame_s = frame_fn(sat_s);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        bit_s     = bit_r;
        shreg_s   = shreg_r;
        dato_s    = dato_r;
        sync_n_s  = sync_n_r;
        sclk_s    = sclk_r;
        sdo_s     = sdo_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        overrun_s = overrun_r;
        case (state_r)
            IDLE: begin
                if (bus.bandera) begin
                    state_s  = SHIFT;
                    dato_s   = sat_s;
                    sdo_s    = frame_s[FW-1];
                    shreg_s  = {frame_s[FW-2:0], 1'b0};
                    phase_s  = {PW{1'b0}};
                    bit_s    = {BW{1'b0}};
                    sync_n_s = 1'b0;
                    sclk_s   = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            SHIFT: begin
                if (bus.bandera) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                phase_s = phase_r + PW'(1);
                if (phase_r == PW'(DIV - 1)) begin
                    sclk_s = 1'b0;
                end else if (phase_r == PW'(2 * DIV - 1)) begin
                    phase_s = {PW{1'b0}};
                    if (bit_r == BW'(FW - 1)) begin
                        state_s  = DONE;
                        sync_n_s = 1'b1;
                        sclk_s   = 1'b0;
                        sdo_s    = 1'b0;
                        done_s   = 1'b1;
                    end else begin
                        // sdo only moves together with the sclk rising edge
                        bit_s   = bit_r + BW'(1);
                        sclk_s  = 1'b1;
                        sdo_s   = shreg_r[FW-1];
                        shreg_s = {shreg_r[FW-2:0], 1'b0};
                    end
                end else begin
                    sclk_s = sclk_r;
                end
            end
            DONE: begin
                if (bus.bandera) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                state_s  = IDLE;
                busy_s   = 1'b0;
                sync_n_s = 1'b1;
                sclk_s   = 1'b0;
            end
            default: begin
                state_s  = IDLE;
                busy_s   = 1'b0;
                sync_n_s = 1'b1;
                sclk_s   = 1'b0;
                sdo_s    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            phase_r   <= {PW{1'b0}};
            bit_r     <= {BW{1'b0}};
            shreg_r   <= {FW{1'b0}};
            dato_r    <= {DAC_W{1'b0}};
            sync_n_r  <= 1'b1;
            sclk_r    <= 1'b0;
            sdo_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            phase_r   <= phase_s;
            bit_r     <= bit_s;
            shreg_r   <= shreg_s;
            dato_r    <= dato_s;
            sync_n_r  <= sync_n_s;
            sclk_r    <= sclk_s;
            sdo_r     <= sdo_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            overrun_r <= overrun_s;
        end
    end

    assign bus.dato_sat = dato_r;
    assign bus.sync_n   = sync_n_r;
    assign bus.sclk     = sclk_r;
    assign bus.sdo      = sdo_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overrun  = overrun_r;
endmodule

// File: tb/tb_desplazador_dac_tx.sv
// Bench for desplazador_dac_tx: timeline model of each frame checked every cycle,
// plus directed literal frames, overrun, reset-abort and random products.
module tb_desplazador_dac_tx;
    localparam int FW  = 16;
    localparam int DIV = 2;
    localparam int FWB = FW * 2 * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    desplazador_dac_tx_if #(.N(25), .DAC_W(12)) bus ();
    desplazador_dac_tx #(.N(25), .FRAC(12), .DAC_W(12), .CTRL(4'b0011), .DIV(2))
        u_dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] m_sat(input logic [49:0] fk);
        longint v;
        v = $signed(fk);
        v = v >>> 12;
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return v[11:0];
    endfunction

    function automatic logic [15:0] m_frame(input logic [11:0] d);
        logic [11:0] ob;
        ob = d + 12'h800;
        return {4'b0011, ob};
    endfunction

    function automatic logic [49:0] mkfk(input longint v);
        return v[49:0];
    endfunction

    // Model: a frame is just "accepted at edge t0"; outputs follow from d = edges since t0.
    int          e = 0;
    int          t0 = 0;
    bit          act = 1'b0;
    logic [15:0] frame_m = 16'h0000;
    logic [11:0] dato_m = 12'h000;
    bit          ovr_m = 1'b0;

    always @(posedge clk) begin
        e++;
        if (reset) begin
            act = 1'b0; dato_m = 12'h000; ovr_m = 1'b0;
        end else if (bus.bandera) begin
            if (act && (e - 1 - t0) <= FWB) ovr_m = 1'b1;
            else begin
                act = 1'b1; t0 = e;
                dato_m = m_sat(bus.fk_in);
                frame_m = m_frame(dato_m);
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int d;
            bit in_shift;
            d = e - t0;
            in_shift = act && d >= 0 && d < FWB;
            chk("sync_n", 32'(bus.sync_n), 32'(!in_shift));
            chk("sclk", 32'(bus.sclk), 32'(in_shift && ((d % (2 * DIV)) < DIV)));
            chk("busy", 32'(bus.busy), 32'(act && d >= 0 && d <= FWB));
            chk("done", 32'(bus.done), 32'(act && d == FWB));
            chk("overrun", 32'(bus.overrun), 32'(ovr_m));
            chk("dato_sat", 32'(bus.dato_sat), 32'(dato_m));
            if (in_shift) chk("sdo", 32'(bus.sdo), 32'(frame_m[FW - 1 - d / (2 * DIV)]));
        end
    end

    // Frame capture: collect sdo on each sclk rise, latch on done.
    logic [15:0] acc = 16'h0000, last_frame = 16'h0000;
    int rises = 0, last_rises = 0, done_seen = 0;
    logic prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            last_frame = acc; last_rises = rises; done_seen++;
        end
        if (bus.sync_n !== 1'b0) begin
            acc = 16'h0000; rises = 0;
        end else if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
            acc = {acc[14:0], bus.sdo}; rises++;
        end
        prev_sclk = bus.sclk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (act && (e - t0) <= FWB && k < 300) begin
            tick();
            k++;
        end
        chk("wait_idle_bound", 32'(k < 300), 32'd1);
    endtask

    task automatic run_frame(input string name, input logic [49:0] fk,
                             input logic [11:0] exp_dato, input logic [15:0] exp_frame);
        int n = 0;
        wait_idle();
        bus.bandera = 1'b1; bus.fk_in = fk;
        tick();
        bus.bandera = 1'b0;
        bus.fk_in = 50'(64'($urandom));
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) break;
        end
        #1;
        chk({name, "_done_cycle"}, 32'(n), 32'd65);
        chk({name, "_dato"}, 32'(bus.dato_sat), 32'(exp_dato));
        chk({name, "_frame"}, 32'(last_frame), 32'(exp_frame));
        chk({name, "_rises"}, 32'(last_rises), 32'd16);
    endtask

    initial begin
        logic [63:0] r;
        longint v;
        int ds;
        bus.bandera = 1'b0;
        bus.fk_in = 50'd0;

        // Hand-computed values pin the model itself.
        chk("pin_sat_pos", 32'(m_sat(mkfk(300 * 4096))), 32'h12C);
        chk("pin_frame_pos", 32'(m_frame(12'h12C)), 32'h392C);
        chk("pin_sat_m1", 32'(m_sat(mkfk(-1))), 32'hFFF);
        chk("pin_sat_hi", 32'(m_sat(mkfk(5000 * 4096))), 32'h7FF);
        chk("pin_frame_lo", 32'(m_frame(m_sat(mkfk(-5000 * 4096)))), 32'h3000);

        repeat (2) tick();
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sync_n", 32'(bus.sync_n), 32'd1);
        chk("rst_sclk", 32'(bus.sclk), 32'd0);
        chk("rst_sdo", 32'(bus.sdo), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dato", 32'(bus.dato_sat), 32'd0);
        tick();

        run_frame("pos", mkfk(300 * 4096), 12'h12C, 16'h392C);
        run_frame("neg", mkfk(-5 * 4096), 12'hFFB, 16'h37FB);
        run_frame("floor", mkfk(-1), 12'hFFF, 16'h37FF);
        run_frame("sat_hi", mkfk(5000 * 4096), 12'h7FF, 16'h3FFF);
        run_frame("sat_lo", mkfk(-5000 * 4096), 12'h800, 16'h3000);
        chk("no_overrun_yet", 32'(bus.overrun), 32'd0);

        // Overrun: strobes at t0+10 and in the DONE cycle, restart at t0+66.
        wait_idle();
        bus.bandera = 1'b1; bus.fk_in = mkfk(300 * 4096);
        tick();
        bus.bandera = 1'b0;
        repeat (9) tick();
        bus.bandera = 1'b1; bus.fk_in = mkfk(-5000 * 4096);
        tick();
        bus.bandera = 1'b0;
        repeat (54) tick();
        bus.bandera = 1'b1;
        tick();
        bus.fk_in = mkfk(-5 * 4096);
        tick();
        bus.bandera = 1'b0;
        @(negedge clk);
        #1;
        chk("ovr_frame_intact", 32'(last_frame), 32'h392C);
        chk("ovr_sticky", 32'(bus.overrun), 32'd1);
        chk("ovr_restart_busy", 32'(bus.busy), 32'd1);
        chk("ovr_restart_dato", 32'(bus.dato_sat), 32'hFFB);

        // Reset at t0+20 aborts the frame without a done pulse.
        wait_idle();
        bus.bandera = 1'b1; bus.fk_in = mkfk(1000 * 4096);
        tick();
        bus.bandera = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        #1;
        ds = done_seen;
        chk("abort_sync_n", 32'(bus.sync_n), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_overrun", 32'(bus.overrun), 32'd0);
        repeat (80) tick();
        chk("abort_no_done", 32'(done_seen), 32'(ds));
        run_frame("after_abort", mkfk(-5000 * 4096), 12'h800, 16'h3000);

        // Random products, random gaps, occasional strobes while busy.
        for (int i = 0; i < 20; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
            case ($urandom_range(0, 2))
                0: begin
                    r = {$urandom, $urandom};
                    bus.fk_in = r[49:0];
                end
                1: begin
                    v = longint'($urandom_range(0, 12000)) - 64'sd6000;
                    bus.fk_in = mkfk(v * 4096 + longint'($urandom_range(0, 4095)));
                end
                default: begin
                    v = ($urandom_range(0, 1) == 0) ? 64'sd2046 : -64'sd2049;
                    v = v + longint'($urandom_range(0, 2));
                    bus.fk_in = mkfk(v * 4096 + longint'($urandom_range(0, 4095)));
                end
            endcase
            bus.bandera = 1'b1;
            tick();
            bus.bandera = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 60)) tick();
                bus.bandera = 1'b1;
                tick();
                bus.bandera = 1'b0;
            end
        end
        wait_idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
